// File: rtl/port_request_forwarder_if.sv
// Port request forwarder bus bundle.
// Groups the priority-stage handshake (request vector, active vector,
// selection, acks) and the consumer-side valid/ready queue head.
//   master : request/consumer side (drives requests, selection, OutReady)
//   slave  : the forwarder itself
interface port_request_forwarder_if #(
    parameter int PORTCOUNT     = 4,
    parameter int PORTADDRWIDTH = 2,
    parameter int DATAWIDTH     = 32
);
    logic [PORTCOUNT-1:0]           PortReqValid;
    logic [PORTCOUNT*DATAWIDTH-1:0] PortReqData;
    logic [PORTCOUNT-1:0]           PortActiveVector;
    logic [PORTADDRWIDTH-1:0]       PortSelection;
    logic [PORTCOUNT-1:0]           PortACK;
    logic                           OutValid;
    logic [DATAWIDTH-1:0]           OutData;
    logic [PORTADDRWIDTH-1:0]       OutPortID;
    logic                           OutReady;
    logic                           Full;

    modport master (
        output PortReqValid, PortReqData, PortSelection, OutReady,
        input  PortActiveVector, PortACK, OutValid, OutData, OutPortID, Full
    );

    modport slave (
        input  PortReqValid, PortReqData, PortSelection, OutReady,
        output PortActiveVector, PortACK, OutValid, OutData, OutPortID, Full
    );
endinterface

// File: rtl/port_request_forwarder.sv
// Port request forwarder.
// Exports pending requests to the round-robin priority stage, takes back
// its PortSelection, acks the chosen port and captures its request into a
// 2-entry FIFO read by a single consumer over valid/ready.
// Ports:
//   clk          sole clock, rising edge
//   async_rst_n  asynchronous active-low reset
//   clk_en       global advance enable; everything frozen when low
//   bus          port_request_forwarder_if.slave (requests, selection,
//                acks, active vector, queue head, Full)
//
// state | meaning
// EMPTY | no entries queued, OutValid low
// ONE   | one entry queued
// FULL  | two entries queued; active vector masked, no grants
module port_request_forwarder #(
    parameter int PORTCOUNT     = 4,
    parameter int PORTADDRWIDTH = 2,
    parameter int DATAWIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     clk_en,
    port_request_forwarder_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATAWIDTH-1:0]     entryData [2];
    logic [PORTADDRWIDTH-1:0] entryId   [2];
    logic                     wrPtr;
    logic                     rdPtr;

    logic                 selValid;
    logic [DATAWIDTH-1:0] selData;
    logic                 isFull;
    logic                 push;
    logic                 pop;
    logic [PORTCOUNT-1:0] ackVec;

    // Matching against each legal index rather than indexing directly means
    // an out-of-range selection simply matches nothing and is rejected.
    always_comb begin
        selValid = 1'b0;
        selData  = '0;
        for (int i = 0; i < PORTCOUNT; i++) begin
            if (bus.PortSelection == PORTADDRWIDTH'(i)) begin
                selValid = bus.PortReqValid[i];
                selData  = bus.PortReqData[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Full comes from the registered state only: a simultaneous pop never
    // opens a slot for a push in the same cycle.
    assign isFull = (state == FULL);
    assign push   = async_rst_n && clk_en && !isFull && selValid;
    assign pop    = clk_en && (state != EMPTY) && bus.OutReady;

    always_comb begin
        ackVec = '0;
        for (int i = 0; i < PORTCOUNT; i++) begin
            ackVec[i] = push && (bus.PortSelection == PORTADDRWIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: if (push) stateNext = ONE;
            ONE: begin
                if (push && !pop)      stateNext = FULL;
                else if (pop && !push) stateNext = EMPTY;
            end
            FULL: if (pop) stateNext = ONE;
            default: stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                entryData[i] <= '0;
                entryId[i]   <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
        end else begin
            if (push) begin
                entryData[wrPtr] <= selData;
                entryId[wrPtr]   <= bus.PortSelection;
                wrPtr            <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
        end
    end

    // Masking while full or stalled keeps the priority index from advancing
    // on cycles that cannot produce a grant.
    assign bus.PortActiveVector = (async_rst_n && clk_en && !isFull) ? bus.PortReqValid : '0;
    assign bus.PortACK          = ackVec;
    assign bus.OutValid         = (state != EMPTY);
    assign bus.OutData          = entryData[rdPtr];
    assign bus.OutPortID        = entryId[rdPtr];
    assign bus.Full             = isFull;
endmodule

// File: tb/tb_port_request_forwarder.sv
module tb_port_request_forwarder;
    localparam int PC = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;
    logic clk_en = 1'b0;

    port_request_forwarder_if #(.PORTCOUNT(PC), .PORTADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();
    port_request_forwarder_if #(.PORTCOUNT(3),  .PORTADDRWIDTH(AW), .DATAWIDTH(DW)) bus3 ();

    port_request_forwarder #(.PORTCOUNT(PC), .PORTADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .bus(bus)
    );

    port_request_forwarder #(.PORTCOUNT(3), .PORTADDRWIDTH(AW), .DATAWIDTH(DW)) dut3 (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .bus(bus3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmpEn = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents in grant order.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] id;
    } entry_t;
    entry_t mq[$];

    function automatic bit modelSelValid();
        int s;
        s = int'(bus.PortSelection);
        return (s < PC) && bus.PortReqValid[s];
    endfunction

    function automatic bit modelPush();
        return clk_en && (mq.size() < 2) && modelSelValid();
    endfunction

    always @(posedge clk or negedge async_rst_n) begin
        entry_t e;
        bit doPop;
        bit doPush;
        if (!async_rst_n) begin
            mq.delete();
        end else begin
            doPop  = clk_en && (mq.size() > 0) && bus.OutReady;
            doPush = modelPush();
            e.id   = bus.PortSelection;
            e.data = bus.PortReqData[int'(bus.PortSelection)*DW +: DW];
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        logic [PC-1:0] expPav;
        logic [PC-1:0] expAck;
        if (async_rst_n && cmpEn) begin
            expPav = (clk_en && mq.size() < 2) ? bus.PortReqValid : '0;
            expAck = modelPush() ? PC'(1 << int'(bus.PortSelection)) : '0;
            chk("PortActiveVector", 64'(bus.PortActiveVector), 64'(expPav));
            chk("PortACK", 64'(bus.PortACK), 64'(expAck));
            chk("OutValid", 64'(bus.OutValid), 64'(mq.size() != 0));
            chk("Full", 64'(bus.Full), 64'(mq.size() == 2));
            if (mq.size() != 0) begin
                chk("OutData", 64'(bus.OutData), 64'(mq[0].data));
                chk("OutPortID", 64'(bus.OutPortID), 64'(mq[0].id));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Stimulus side: a round-robin priority stage fed by PortActiveVector.
    int rrPtr = 0;
    bit useRr = 1'b0;
    int policy = 0;
    logic [PC-1:0] ackNow;
    logic [AW-1:0] selNow;

    function automatic logic [AW-1:0] rrPick(input logic [PC-1:0] vec);
        for (int k = 0; k < PC; k++) begin
            if (vec[(rrPtr + k) % PC]) return AW'((rrPtr + k) % PC);
        end
        return AW'(3);
    endfunction

    task automatic settle();
        #1;
        if (useRr) bus.PortSelection = rrPick(bus.PortActiveVector);
        #1;
    endtask

    task automatic advance();
        ackNow = bus.PortACK;
        selNow = bus.PortSelection;
        @(posedge clk);
        #1;
        if (ackNow != '0) rrPtr = (int'(selNow) + 1) % PC;
        for (int i = 0; i < PC; i++) begin
            if (ackNow[i]) begin
                if (policy == 1 || (policy == 2 && $urandom_range(0, 1) == 1)) begin
                    bus.PortReqData[i*DW +: DW] = $urandom;
                end else begin
                    bus.PortReqValid[i] = 1'b0;
                end
            end else if (policy == 2 && !bus.PortReqValid[i] && $urandom_range(0, 2) == 0) begin
                bus.PortReqValid[i] = 1'b1;
                bus.PortReqData[i*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic doReset();
        async_rst_n = 1'b0;
        bus.PortReqValid = '0;
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        rrPtr = 0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        bus.PortReqValid  = 4'b1111;
        bus.PortReqData   = '0;
        bus.PortSelection = '0;
        bus.OutReady      = 1'b0;
        bus3.PortReqValid  = '0;
        bus3.PortReqData   = '0;
        bus3.PortSelection = '0;
        bus3.OutReady      = 1'b0;
        clk_en = 1'b1;

        // Reset holds every output low even with requests and clk_en present.
        @(posedge clk);
        #1;
        chk("rst_OutValid", 64'(bus.OutValid), 64'd0);
        chk("rst_Full", 64'(bus.Full), 64'd0);
        chk("rst_PortACK", 64'(bus.PortACK), 64'd0);
        chk("rst_PortActiveVector", 64'(bus.PortActiveVector), 64'd0);
        chk("rst_OutData", 64'(bus.OutData), 64'd0);
        chk("rst_OutPortID", 64'(bus.OutPortID), 64'd0);
        async_rst_n = 1'b1;
        bus.PortReqValid = '0;
        cmpEn = 1'b1;

        // Single grant, then push and pop together from one entry.
        policy = 0; useRr = 1'b0;
        bus.PortReqValid = 4'b0100;
        bus.PortReqData[2*DW +: DW] = 32'hA5A50002;
        bus.PortSelection = 2'd2;
        settle();
        chk("t1_PortACK", 64'(bus.PortACK), 64'h4);
        advance();
        bus.PortReqValid = 4'b0100;
        bus.PortReqData[2*DW +: DW] = 32'h11112222;
        bus.OutReady = 1'b1;
        settle();
        chk("t1_OutValid", 64'(bus.OutValid), 64'd1);
        chk("t1_OutData", 64'(bus.OutData), 64'hA5A50002);
        chk("t1_OutPortID", 64'(bus.OutPortID), 64'd2);
        chk("t1_Full", 64'(bus.Full), 64'd0);
        chk("pp_PortACK", 64'(bus.PortACK), 64'h4);
        advance();
        bus.OutReady = 1'b0;
        settle();
        chk("pp_OutData", 64'(bus.OutData), 64'h11112222);
        chk("pp_OutValid", 64'(bus.OutValid), 64'd1);
        chk("pp_Full", 64'(bus.Full), 64'd0);
        advance();

        // No request / out-of-range selection.
        doReset();
        bus.PortReqValid = '0;
        bus.PortSelection = 2'd3;
        bus3.PortReqValid = 3'b111;
        bus3.PortSelection = 2'd3;
        settle();
        chk("idle_PortACK", 64'(bus.PortACK), 64'd0);
        chk("pc3_PortACK", 64'(bus3.PortACK), 64'd0);
        chk("pc3_PortActiveVector", 64'(bus3.PortActiveVector), 64'h7);
        advance();
        settle();
        chk("idle_OutValid", 64'(bus.OutValid), 64'd0);
        chk("pc3_OutValid", 64'(bus3.OutValid), 64'd0);
        advance();
        bus3.PortReqValid = '0;

        // Round-robin with all ports requesting, one grant per cycle.
        doReset();
        policy = 1; useRr = 1'b1;
        bus.PortReqValid = 4'b1111;
        for (int i = 0; i < PC; i++) bus.PortReqData[i*DW +: DW] = $urandom;
        bus.OutReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("rr_PortACK", 64'(bus.PortACK), 64'(1 << (k % 4)));
            if (k > 0) chk("rr_OutPortID", 64'(bus.OutPortID), 64'((k - 1) % 4));
            advance();
        end

        // Fill to full with ports 0 and 3, then a single pop.
        doReset();
        bus.OutReady = 1'b0;
        bus.PortReqValid = 4'b1001;
        bus.PortReqData[0*DW +: DW] = 32'hD0D00000;
        bus.PortReqData[3*DW +: DW] = 32'hD3D30003;
        settle();
        chk("full_ack0", 64'(bus.PortACK), 64'h1);
        advance();
        settle();
        chk("full_ack1", 64'(bus.PortACK), 64'h8);
        advance();
        settle();
        chk("full_Full", 64'(bus.Full), 64'd1);
        chk("full_PortActiveVector", 64'(bus.PortActiveVector), 64'd0);
        chk("full_PortACK", 64'(bus.PortACK), 64'd0);
        chk("full_OutData", 64'(bus.OutData), 64'hD0D00000);
        advance();
        bus.OutReady = 1'b1;
        settle();
        chk("full_popcycle_ack", 64'(bus.PortACK), 64'd0);
        advance();
        bus.OutReady = 1'b0;
        settle();
        chk("full_after_pop_Full", 64'(bus.Full), 64'd0);
        chk("full_after_pop_ack", 64'(bus.PortACK), 64'h1);
        chk("full_after_pop_OutPortID", 64'(bus.OutPortID), 64'd3);
        advance();

        // Asynchronous reset in the middle of a cycle with two entries.
        settle();
        chk("mid_pre_Full", 64'(bus.Full), 64'd1);
        async_rst_n = 1'b0;
        #1;
        chk("mid_OutValid", 64'(bus.OutValid), 64'd0);
        chk("mid_Full", 64'(bus.Full), 64'd0);
        chk("mid_OutData", 64'(bus.OutData), 64'd0);
        chk("mid_PortACK", 64'(bus.PortACK), 64'd0);
        chk("mid_PortActiveVector", 64'(bus.PortActiveVector), 64'd0);
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        rrPtr = 0;

        // clk_en low freezes everything.
        policy = 0;
        bus.PortReqValid = 4'b0010;
        bus.PortReqData[1*DW +: DW] = 32'hC1C10001;
        cycles(1);
        clk_en = 1'b0;
        bus.PortReqValid = 4'b1111;
        bus.OutReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("ce_PortACK", 64'(bus.PortACK), 64'd0);
            chk("ce_PortActiveVector", 64'(bus.PortActiveVector), 64'd0);
            chk("ce_OutData", 64'(bus.OutData), 64'hC1C10001);
            advance();
        end
        clk_en = 1'b1;
        cycles(3);

        // Randomized traffic against the model.
        doReset();
        policy = 2;
        for (int k = 0; k < 600; k++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            bus.OutReady = ($urandom_range(0, 9) < 6);
            useRr = ($urandom_range(0, 4) != 0);
            if (!useRr) bus.PortSelection = AW'($urandom_range(0, 3));
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
